// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction requester, data requester and shared memory
// port signals for mem_port_arbiter.
// slave  : the arbiter's view (takes requests, drives the memory port).
// master : the environment's view (requesters plus the memory itself).
// Handshake: a requester holds x_valid with stable fields until it wants to
// stop; the arbiter answers with a one-cycle x_ready carrying x_data. On the
// memory side m_valid is held with stable fields until a cycle where
// m_ready=1, in which m_data is taken.
interface mem_port_arbiter_if;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_ready;
  logic [31:0] i_data;

  logic        d_valid;
  logic [63:0] d_addr;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_ready;
  logic [63:0] d_data;

  logic        m_valid;
  logic [63:0] m_addr;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_ready;
  logic [63:0] m_data;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_strobe, d_wdata, m_ready, m_data,
    output i_ready, i_data, d_ready, d_data, m_valid, m_addr, m_strobe, m_wdata
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_strobe, d_wdata, m_ready, m_data,
    input  i_ready, i_data, d_ready, d_data, m_valid, m_addr, m_strobe, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter onto a single memory port. Data (D) has fixed
// priority over instruction fetch (I). One transaction is in flight at a
// time: IDLE -> BUSY_x (memory access) -> RESP_x (one-cycle ready) -> IDLE.
// Optional macro ARB_STARVE_GUARD_EN adds a 4-bit starvation counter that
// forces an I grant after STARVE_LIMIT consecutive D grants while I waits.
// state_dbg exposes the FSM state: 0 IDLE, 1 BUSY_I, 2 BUSY_D, 3 RESP_I,
// 4 RESP_D.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t      state, next_state;
  logic        grant_i, grant_d;
  logic        starve_hold;

  logic [63:0] addr_q;
  logic [7:0]  strobe_q;
  logic [63:0] wdata_q;
  logic        i_hi_q;
  logic [31:0] i_data_q;
  logic [63:0] d_data_q;

  // Byte offset bits of the fetch address do not affect the aligned access.
  logic        unused_i_addr_lo;
  assign unused_i_addr_lo = ^bus.i_addr[1:0];

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  // Hold off D when I has waited through STARVE_LIMIT D grants.
  assign starve_hold = bus.i_valid && (starve_cnt == 4'(STARVE_LIMIT));

  // Starvation counter: counts D grants made while I waits, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (grant_i) begin
        starve_cnt <= 4'd0;
      end else if (grant_d && bus.i_valid) begin
        if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      end else if (!bus.i_valid) begin
        starve_cnt <= 4'd0;
      end
    end
  end
`else
  assign starve_hold = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and grant decode; requests are sampled only in IDLE.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_valid && !starve_hold) begin
          grant_d    = 1'b1;
          next_state = BUSY_D;
        end else if (bus.i_valid) begin
          grant_i    = 1'b1;
          next_state = BUSY_I;
        end
      end
      BUSY_I:  if (bus.m_ready) next_state = RESP_I;
      BUSY_D:  if (bus.m_ready) next_state = RESP_D;
      RESP_I:  next_state = IDLE;
      RESP_D:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch: captured on grant, held stable through BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= 64'd0;
      strobe_q <= 8'd0;
      wdata_q  <= 64'd0;
      i_hi_q   <= 1'b0;
    end else if (grant_d) begin
      addr_q   <= bus.d_addr;
      strobe_q <= bus.d_strobe;
      wdata_q  <= bus.d_wdata;
    end else if (grant_i) begin
      addr_q   <= {bus.i_addr[63:3], 3'b000};
      strobe_q <= 8'h00;
      wdata_q  <= 64'd0;
      i_hi_q   <= bus.i_addr[2];
    end
  end

  // Response registers: loaded on the memory handshake, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_data_q <= 32'd0;
      d_data_q <= 64'd0;
    end else if (bus.m_ready) begin
      if (state == BUSY_I) i_data_q <= i_hi_q ? bus.m_data[63:32] : bus.m_data[31:0];
      if (state == BUSY_D) d_data_q <= bus.m_data;
    end
  end

  assign bus.m_valid  = (state == BUSY_I) || (state == BUSY_D);
  assign bus.m_addr   = addr_q;
  assign bus.m_strobe = strobe_q;
  assign bus.m_wdata  = wdata_q;
  assign bus.i_ready  = (state == RESP_I);
  assign bus.d_ready  = (state == RESP_D);
  assign bus.i_data   = i_data_q;
  assign bus.d_data   = d_data_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions, a memory responder that
// checks request fields every BUSY cycle, and a response monitor that pops
// an expected queue on every i_ready/d_ready pulse.
module tb_mem_port_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] state_dbg;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] mdata;
    int          lat;
  } mem_txn_t;

  mem_txn_t     mem_q[$];
  logic [64:0]  exp_q[$];   // {is_d, response data}
  int           checks = 0;
  int           errors = 0;

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_mem(input logic [63:0] addr, input logic [7:0] strobe,
                          input logic [63:0] wdata, input logic [63:0] mdata, input int lat);
    mem_txn_t t;
    t.addr = addr; t.strobe = strobe; t.wdata = wdata; t.mdata = mdata; t.lat = lat;
    mem_q.push_back(t);
  endtask

  task automatic push_rsp(input logic is_d, input logic [63:0] data);
    exp_q.push_back({is_d, data});
  endtask

  // Response check: each ready pulse must match the next expected response.
  task automatic check_rsp(input logic is_d, input logic [63:0] got);
    logic [64:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rsp_unexpected is_d=%0b got=%h exp=none", is_d, got);
    end else begin
      e = exp_q.pop_front();
      if (e !== {is_d, got}) begin
        errors++;
        $display("FAIL rsp is_d=%0b got=%h exp_is_d=%0b exp=%h", is_d, got, e[64], e[63:0]);
      end
    end
  endtask

  // Monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.i_ready) check_rsp(1'b0, {32'h0, bus.i_data});
      if (bus.d_ready) check_rsp(1'b1, bus.d_data);
    end
  end

  // Memory responder: checks fields each BUSY cycle, answers after lat cycles.
  initial begin
    mem_txn_t cur;
    int busy_cnt;
    busy_cnt    = 0;
    bus.m_ready = 1'b0;
    bus.m_data  = 64'd0;
    cur.addr = 64'd0; cur.strobe = 8'd0; cur.wdata = 64'd0; cur.mdata = 64'd0; cur.lat = 1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cnt    = 0;
        bus.m_ready = 1'b0;
      end else if (bus.m_valid) begin
        if (busy_cnt == 0) begin
          if (mem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_unexpected got_addr=%h exp=none", bus.m_addr);
          end else begin
            cur = mem_q.pop_front();
          end
        end
        check64("m_addr", bus.m_addr, cur.addr);
        check64("m_strobe", {56'd0, bus.m_strobe}, {56'd0, cur.strobe});
        check64("m_wdata", bus.m_wdata, cur.wdata);
        busy_cnt++;
        if (busy_cnt >= cur.lat) begin
          bus.m_ready = 1'b1;
          bus.m_data  = cur.mdata;
          busy_cnt    = 0;
        end else begin
          bus.m_ready = 1'b0;
        end
      end else begin
        bus.m_ready = 1'b0;
      end
    end
  end

  // Wait (bounded) for a ready pulse of the given requester.
  task automatic wait_ready(input logic is_d, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (is_d ? bus.d_ready : bus.i_ready) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=no_ready exp=ready", name);
    end
  endtask

  task automatic do_i(input logic [63:0] addr, input logic [63:0] mdata, input int lat);
    push_mem({addr[63:3], 3'b000}, 8'h00, 64'd0, mdata, lat);
    push_rsp(1'b0, {32'h0, addr[2] ? mdata[63:32] : mdata[31:0]});
    bus.i_valid = 1'b1;
    bus.i_addr  = addr;
    wait_ready(1'b0, "do_i");
    bus.i_valid = 1'b0;
  endtask

  task automatic do_d(input logic [63:0] addr, input logic [7:0] strobe,
                      input logic [63:0] wdata, input logic [63:0] mdata, input int lat);
    push_mem(addr, strobe, wdata, mdata, lat);
    push_rsp(1'b1, mdata);
    bus.d_valid  = 1'b1;
    bus.d_addr   = addr;
    bus.d_strobe = strobe;
    bus.d_wdata  = wdata;
    wait_ready(1'b1, "do_d");
    bus.d_valid  = 1'b0;
  endtask

  // Directed stimulus.
  initial begin
    int n;
    reset        = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_addr   = 64'd0;
    bus.d_valid  = 1'b0;
    bus.d_addr   = 64'd0;
    bus.d_strobe = 8'd0;
    bus.d_wdata  = 64'd0;
    #12;
    check64("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    check64("rst_i_ready", {63'd0, bus.i_ready}, 64'd0);
    check64("rst_d_ready", {63'd0, bus.d_ready}, 64'd0);
    check64("rst_m_addr", bus.m_addr, 64'd0);
    check64("rst_m_wdata", bus.m_wdata, 64'd0);
    check64("rst_i_data", {32'd0, bus.i_data}, 64'd0);
    check64("rst_d_data", bus.d_data, 64'd0);
    check64("rst_state", {61'd0, state_dbg}, 64'd0);

    // I-only fetch, upper word, ready on the 2nd BUSY cycle; first grant
    // right after reset release.
    push_mem(64'h8000_0000, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 2);
    push_rsp(1'b0, 64'h0000_0000_1122_3344);
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h8000_0004;
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    check64("first_grant_m_valid", {63'd0, bus.m_valid}, 64'd1);
    wait_ready(1'b0, "i_only");
    bus.i_valid = 1'b0;
    @(negedge clk);
    check64("i_data_hold", {32'd0, bus.i_data}, 64'h1122_3344);

    // D write held until m_ready, then D read at minimum latency.
    do_d(64'h100, 8'h0F, 64'hAB, 64'h0123_4567_89AB_CDEF, 3);
    do_d(64'h108, 8'h00, 64'h0, 64'hFEDC_BA98_7654_3210, 1);
    // I fetch, lower word.
    do_i(64'h0000_0000_0000_1238, 64'hAAAA_BBBB_CCCC_DDDD, 1);

    // I dropped mid-BUSY: access completes, i_ready still pulses.
    push_mem(64'h40, 8'h00, 64'd0, 64'hCAFE_F00D_1234_5678, 3);
    push_rsp(1'b0, 64'h0000_0000_1234_5678);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h40;
    @(negedge clk);
    bus.i_valid = 1'b0;
    check64("drop_m_valid", {63'd0, bus.m_valid}, 64'd1);
    wait_ready(1'b0, "i_drop");
    @(negedge clk);
    check64("drop_back_idle", {61'd0, state_dbg}, 64'd0);

    // Contention: both valid for six transactions.
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        push_mem(64'h2000_0000, 8'h00, 64'd0, 64'h5555_0000_9999_0000 + 64'(k), 1);
        push_rsp(1'b0, 64'h9999_0000 + 64'(k));
      end else begin
        push_mem(64'h300, 8'h00, 64'h55, 64'hD000_0000_0000_0000 + 64'(k), 1);
        push_rsp(1'b1, 64'hD000_0000_0000_0000 + 64'(k));
      end
    end
`else
    for (int k = 0; k < 6; k++) begin
      push_mem(64'h300, 8'h00, 64'h55, 64'hD000_0000_0000_0000 + 64'(k), 1);
      push_rsp(1'b1, 64'hD000_0000_0000_0000 + 64'(k));
    end
`endif
    bus.i_valid  = 1'b1;
    bus.i_addr   = 64'h2000_0000;
    bus.d_valid  = 1'b1;
    bus.d_addr   = 64'h300;
    bus.d_strobe = 8'h00;
    bus.d_wdata  = 64'h55;
    n = 0;
    for (int k = 0; k < 200 && n < 6; k++) begin
      @(negedge clk);
      if (bus.i_ready || bus.d_ready) n++;
    end
    bus.i_valid = 1'b0;
    bus.d_valid = 1'b0;
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL contention_count got=%0d exp=6", n);
    end

    // Reset mid-BUSY_D: abandoned, no ready afterwards.
    push_mem(64'h400, 8'hFF, 64'h77, 64'h1, 20);
    @(negedge clk);
    bus.d_valid  = 1'b1;
    bus.d_addr   = 64'h400;
    bus.d_strobe = 8'hFF;
    bus.d_wdata  = 64'h77;
    @(negedge clk);
    @(negedge clk);
    check64("pre_rst_m_valid", {63'd0, bus.m_valid}, 64'd1);
    #2;
    reset       = 1'b0;
    bus.d_valid = 1'b0;
    #1;
    check64("mid_rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    check64("mid_rst_d_ready", {63'd0, bus.d_ready}, 64'd0);
    check64("mid_rst_state", {61'd0, state_dbg}, 64'd0);
    check64("mid_rst_m_addr", bus.m_addr, 64'd0);
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check64("post_rst_m_valid", {63'd0, bus.m_valid}, 64'd0);

    // Drain: everything expected must have been consumed.
    for (int k = 0; k < 50 && (exp_q.size() != 0 || mem_q.size() != 0); k++) @(negedge clk);
    check64("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check64("mem_q_empty", 64'(mem_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive D grants while I waits (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_valid in 1, i_addr in 64, i_ready out 1, i_data out 32: the instruction-fetch requester.
REQ-005 SHALL have ports d_valid in 1, d_addr in 64, d_strobe in 8, d_wdata in 64, d_ready out 1, d_data out 64: the data requester; any d_strobe bit set means write, all zero means read.
REQ-006 SHALL have ports m_valid out 1, m_addr out 64, m_strobe out 8, m_wdata out 64, m_ready in 1, m_data in 64: the single shared memory port.

Function
REQ-007 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP_I and RESP_D.
REQ-008 IDLE: d_valid grants D; otherwise i_valid grants I; otherwise stays IDLE; on grant, latch requester address/strobe/wdata and go to BUSY_x next cycle.
REQ-009 An I grant SHALL latch m_strobe=8'h00 and m_wdata=0; m_addr={i_addr[63:3],3'b000} for I, d_addr unmodified for D.
REQ-010 BUSY_x: m_valid=1 with latched fields stable; fields SHALL NOT change until m_ready=1.
REQ-011 BUSY_x with m_ready=1: capture m_data into a response register and go to RESP_x; otherwise remain.
REQ-012 RESP_x: assert x_ready for exactly one cycle with registered data, then return to IDLE; new requests are sampled only in IDLE.
REQ-013 i_data SHALL be m_data[63:32] when latched i_addr[2]=1, else m_data[31:0]; d_data SHALL be all 64 bits.
REQ-014 i_ready/d_ready SHALL be 0 outside RESP_I/RESP_D; i_data/d_data hold their last value otherwise.
REQ-015 Requester dropping valid during BUSY_x: memory access completes, x_ready still pulses, and the response is discarded by the requester.
REQ-016 m_valid SHALL be 0 in IDLE and RESP_x; request-to-response minimum latency is 3 cycles (grant, BUSY with m_ready=1, RESP).
REQ-017 Simultaneous i_valid and d_valid in IDLE SHALL grant according to REQ-008 or REQ-025.

Reset
REQ-018 reset low SHALL immediately force state IDLE, m_valid=0, i_ready=0, d_ready=0 and clear all latched fields, response registers and the starvation counter to 0.
REQ-019 Reset asserted mid-BUSY SHALL abandon the transaction; no ready pulse follows release.
REQ-020 First grant after reset release SHALL occur on the first rising edge with reset high and a valid input.

Configuration
REQ-021 Macro ARB_STARVE_GUARD_EN SHALL compile in the starvation guard; when undefined, arbitration is pure fixed D-over-I priority and no counter exists.
REQ-022 With the guard, a 4-bit counter SHALL increment on each D grant made while i_valid=1.
REQ-023 The counter SHALL clear on every I grant.
REQ-024 The counter SHALL clear on any IDLE cycle with i_valid=0.
REQ-025 With the guard, when the counter equals STARVE_LIMIT and both requesters are valid in IDLE, I SHALL be granted.
REQ-026 The counter SHALL saturate and never wrap.

Verification
REQ-027 I-only: i_valid=1, i_addr=0x8000_0004, m_ready on 2nd BUSY cycle, m_data=0x1122_3344_5566_7788 -> i_ready pulses once, i_data=0x1122_3344, m_addr=0x8000_0000.
REQ-028 D write: d_valid=1, d_addr=0x100, d_strobe=0x0F, d_wdata=0xAB -> m_strobe=0x0F, m_wdata=0xAB held until m_ready, then one d_ready pulse.
REQ-029 Contention, guard off: i_valid and d_valid both held for 6 transactions -> all 6 granted D; I waits throughout.
REQ-030 Contention, ARB_STARVE_GUARD_EN, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D.
REQ-031 Reset low during BUSY_D with m_ready=0 -> same cycle m_valid=0; after release, no d_ready pulse for the abandoned request.
REQ-032 i_valid dropped mid-BUSY_I -> m_valid held until m_ready=1, i_ready still pulses once, FSM back to IDLE.
